// File: rtl/systolic_pkg.sv
// ============================================================================
// Module      : systolic_pkg
// Description : Shared state encoding, default array geometry and the drain
//               length helper for the systolic array feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

  localparam int ARR_ROWS = 8;
  localparam int ARR_COLS = 8;
  localparam int DATA_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_SETTLE = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } feeder_state_e;

  // Zero-beat cycles needed after the last activation until every partial
  // sum has left the array; a skewed feed adds the deepest lane's delay.
  function automatic int d_cyc(input int rows, input int cols, input bit skew);
    return skew ? (rows + cols + rows - 1) : (rows + cols);
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_skew_buf.sv
// ============================================================================
// Module      : systolic_skew_buf
// Description : Triangular delay line; lane i of the activation vector is
//               delayed by i cycles, lane 0 passes straight through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_skew_buf
  import systolic_pkg::*;
#(
  parameter int N_ROWS = ARR_ROWS,
  parameter int DATA_W = systolic_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [N_ROWS*DATA_W-1:0] din,
  output logic [N_ROWS*DATA_W-1:0] dout
);

  for (genvar i = 0; i < N_ROWS; i++) begin : g_lane
    if (i == 0) begin : g_pass
      assign dout[DATA_W-1:0] = din[DATA_W-1:0];
    end else begin : g_dly
      logic [DATA_W-1:0] r_dly [i];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < i; s++) r_dly[s] <= '0;
        end else if (flush) begin
          for (int s = 0; s < i; s++) r_dly[s] <= '0;
        end else begin
          r_dly[0] <= din[i*DATA_W +: DATA_W];
          for (int s = 1; s < i; s++) r_dly[s] <= r_dly[s-1];
        end
      end

      assign dout[i*DATA_W +: DATA_W] = r_dly[i-1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ============================================================================
// Module      : systolic_feeder
// Description : Sequences weight load, settle, activation streaming and drain
//               for a systolic array from two valid/ready streams.
//               Optional SYSTOLIC_FEEDER_SKEW_EN adds a triangular lane skew.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N_ROWS = ARR_ROWS,
  parameter int N_COLS = ARR_COLS,
  parameter int DATA_W = systolic_pkg::DATA_W,
  parameter int MAX_K  = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [N_COLS*DATA_W-1:0]     w_data,
  input  logic                         act_valid,
  output logic                         act_ready,
  input  logic [N_ROWS*DATA_W-1:0]     act_data,
  input  logic                         act_last,
  output logic                         load_weight,
  output logic [N_COLS*DATA_W-1:0]     b_in_flat,
  output logic                         block_valid,
  output logic [N_ROWS*DATA_W-1:0]     a_in_flat,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MAX_K+1)-1:0]   k_count,
  output logic                         k_overflow
);

`ifdef SYSTOLIC_FEEDER_SKEW_EN
  localparam bit c_skew = 1'b1;
`else
  localparam bit c_skew = 1'b0;
`endif

  localparam int c_settle = N_COLS + 2;
  localparam int c_drain  = d_cyc(N_ROWS, N_COLS, c_skew);
  localparam int c_tmax   = (c_settle > c_drain) ? c_settle : c_drain;
  localparam int c_tw     = $clog2(c_tmax + 1);
  localparam int c_ww     = $clog2(N_ROWS + 1);
  localparam int c_kw     = $clog2(MAX_K + 1);

  feeder_state_e             r_state;
  logic [c_ww-1:0]           r_wcnt;
  logic [c_tw-1:0]           r_timer;
  logic [c_kw-1:0]           r_k;
  logic                      r_ovf;
  logic                      r_load_weight;
  logic [N_COLS*DATA_W-1:0]  r_b;
  logic                      r_block_valid;
  logic [N_ROWS*DATA_W-1:0]  r_a;
  logic                      r_done;

  logic w_k_last;
  assign w_k_last = (r_k == c_kw'(MAX_K - 1));

  // Array-facing outputs are registered: they show the beat or bubble of the
  // previous cycle, so the array sees one coherent vector per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_wcnt        <= '0;
      r_timer       <= '0;
      r_k           <= '0;
      r_ovf         <= 1'b0;
      r_load_weight <= 1'b0;
      r_b           <= '0;
      r_block_valid <= 1'b0;
      r_a           <= '0;
      r_done        <= 1'b0;
    end else if (abort) begin
      r_state       <= ST_IDLE;
      r_wcnt        <= '0;
      r_timer       <= '0;
      r_load_weight <= 1'b0;
      r_b           <= '0;
      r_block_valid <= 1'b0;
      r_a           <= '0;
      r_done        <= 1'b0;
    end else begin
      r_load_weight <= 1'b0;
      r_block_valid <= 1'b0;
      r_a           <= '0;
      r_done        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD_W;
            r_wcnt  <= '0;
            r_k     <= '0;
            r_ovf   <= 1'b0;
          end
        end
        ST_LOAD_W: begin
          if (w_valid) begin
            r_load_weight <= 1'b1;
            r_b           <= w_data;
            if (r_wcnt == c_ww'(N_ROWS - 1)) begin
              r_wcnt  <= '0;
              r_timer <= '0;
              r_state <= ST_SETTLE;
            end else begin
              r_wcnt <= r_wcnt + c_ww'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (r_timer == c_tw'(c_settle - 1)) begin
            r_timer <= '0;
            r_state <= ST_STREAM;
          end else begin
            r_timer <= r_timer + c_tw'(1);
          end
        end
        ST_STREAM: begin
          r_block_valid <= 1'b1;
          if (act_valid) begin
            r_a <= act_data;
            r_k <= r_k + c_kw'(1);
            if (act_last || w_k_last) begin
              r_timer <= '0;
              r_state <= ST_DRAIN;
              if (!act_last) r_ovf <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          r_block_valid <= 1'b1;
          if (r_timer == c_tw'(c_drain - 1)) begin
            r_timer <= '0;
            r_state <= ST_DONE;
          end else begin
            r_timer <= r_timer + c_tw'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_ready     = (r_state == ST_LOAD_W);
  assign act_ready   = (r_state == ST_STREAM);
  assign busy        = (r_state != ST_IDLE);
  assign load_weight = r_load_weight;
  assign b_in_flat   = r_b;
  assign block_valid = r_block_valid;
  assign done        = r_done;
  assign k_count     = r_k;
  assign k_overflow  = r_ovf;

`ifdef SYSTOLIC_FEEDER_SKEW_EN
  logic w_flush;
  assign w_flush = abort || (r_state == ST_IDLE);

  systolic_skew_buf #(
    .N_ROWS (N_ROWS),
    .DATA_W (DATA_W)
  ) u_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (w_flush),
    .din   (r_a),
    .dout  (a_in_flat)
  );
`else
  assign a_in_flat = r_a;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// ============================================================================
// Module      : tb_systolic_feeder
// Description : Randomised self-checking bench for systolic_feeder against a
//               transaction-level model of the expected array-facing streams.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_systolic_feeder;

  localparam int N_ROWS = 8;
  localparam int N_COLS = 8;
  localparam int DW     = 8;
  localparam int MAX_K  = 12;
  localparam int KW     = $clog2(MAX_K + 1);
  localparam int AW     = N_ROWS * DW;
  localparam int BW     = N_COLS * DW;
`ifdef SYSTOLIC_FEEDER_SKEW_EN
  localparam int D_CYC  = N_ROWS + N_COLS + N_ROWS - 1;
  localparam bit SKEW   = 1'b1;
`else
  localparam int D_CYC  = N_ROWS + N_COLS;
  localparam bit SKEW   = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          w_valid = 1'b0;
  logic [BW-1:0] w_data = '0;
  logic          act_valid = 1'b0;
  logic [AW-1:0] act_data = '0;
  logic          act_last = 1'b0;
  logic          w_ready, act_ready, load_weight, block_valid, busy, done, k_overflow;
  logic [BW-1:0] b_in_flat;
  logic [AW-1:0] a_in_flat;
  logic [KW-1:0] k_count;

  systolic_feeder #(
    .N_ROWS (N_ROWS), .N_COLS (N_COLS), .DATA_W (DW), .MAX_K (MAX_K)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
    .w_valid (w_valid), .w_ready (w_ready), .w_data (w_data),
    .act_valid (act_valid), .act_ready (act_ready), .act_data (act_data),
    .act_last (act_last), .load_weight (load_weight), .b_in_flat (b_in_flat),
    .block_valid (block_valid), .a_in_flat (a_in_flat), .busy (busy),
    .done (done), .k_count (k_count), .k_overflow (k_overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Passive monitor: one record per tile, reset whenever tile_id moves on.
  int            cyc = 0;
  int            tile_id = 0;
  int            mon_id = 0;
  logic [BW-1:0] obs_w[$];
  logic [AW-1:0] obs_a[$];
  int            lw_last = -1, bv_first = -1, bv_last = -1, done_cnt = 0, ovl_cnt = 0;

  always @(negedge clk) begin
    if (tile_id != mon_id) begin
      mon_id = tile_id;
      obs_w.delete();
      obs_a.delete();
      lw_last = -1; bv_first = -1; bv_last = -1; done_cnt = 0; ovl_cnt = 0;
    end
    if (load_weight) begin
      obs_w.push_back(b_in_flat);
      lw_last = cyc;
    end
    if (block_valid) begin
      obs_a.push_back(a_in_flat);
      if (bv_first < 0) bv_first = cyc;
      bv_last = cyc;
    end
    if (load_weight && block_valid) ovl_cnt++;
    if (done) done_cnt++;
    cyc++;
  end

  logic [BW-1:0] tile_w [N_ROWS];
  logic [AW-1:0] tile_a [MAX_K];

  function automatic logic [63:0] rep8(input logic [7:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  task automatic fill_const(input logic [7:0] wv, input logic [7:0] av);
    for (int r = 0; r < N_ROWS; r++) tile_w[r] = rep8(wv);
    for (int k = 0; k < MAX_K; k++) tile_a[k] = rep8(av);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < N_ROWS; r++) tile_w[r] = {$urandom, $urandom};
    for (int k = 0; k < MAX_K; k++) tile_a[k] = {$urandom, $urandom};
  endtask

  task automatic begin_tile(input bit gappy, output bit ok);
    int t;
    tile_id++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_k_count", 64'(k_count), 64'(0));
    chk("start_k_overflow", 64'(k_overflow), 64'(0));
    chk("start_busy", 64'(busy), 64'(1));
    ok = 1'b1;
    for (int r = 0; r < N_ROWS; r++) begin
      if (gappy && $urandom_range(0, 1) == 1) begin
        w_valid = 1'b0;
        @(negedge clk);
      end
      w_valid = 1'b1;
      w_data  = tile_w[r];
      t = 0;
      while (!w_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!w_ready) begin
        chk("w_ready_timeout", 64'(w_ready), 64'(1));
        ok = 1'b0;
        w_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    w_valid = 1'b0;
    t = 0;
    while (!act_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!act_ready) begin
      chk("act_ready_timeout", 64'(act_ready), 64'(1));
      ok = 1'b0;
    end
  endtask

  task automatic run_tile(input int nbeats, input bit give_last, input bit gappy, input bit hold_start);
    logic [AW-1:0] exp_full[$];
    logic [AW-1:0] e;
    int            idx, t, src;
    bit            ok;
    begin_tile(gappy, ok);
    if (!ok) return;
    if (hold_start) start = 1'b1;
    idx = 0;
    while (idx < nbeats) begin
      if (gappy && $urandom_range(0, 2) == 0) begin
        act_valid = 1'b0;
        act_last  = 1'b0;
        act_data  = {$urandom, $urandom};
        exp_full.push_back('0);
      end else begin
        act_valid = 1'b1;
        act_data  = tile_a[idx];
        act_last  = give_last && (idx == nbeats - 1);
        exp_full.push_back(tile_a[idx]);
        idx++;
      end
      chk("act_ready", 64'(act_ready), 64'(1));
      @(negedge clk);
    end
    act_valid = 1'b0;
    act_last  = 1'b0;
    chk("act_ready_drain", 64'(act_ready), 64'(0));
    for (int d = 0; d < D_CYC; d++) exp_full.push_back('0);
    t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 64'(done), 64'(1));
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'(0));
    chk("done_count", 64'(done_cnt), 64'(1));
    chk("k_count", 64'(k_count), 64'(nbeats));
    chk("k_overflow", 64'(k_overflow), 64'(!give_last));
    chk("lw_bv_overlap", 64'(ovl_cnt), 64'(0));
    chk("w_beats", 64'(obs_w.size()), 64'(N_ROWS));
    for (int r = 0; r < N_ROWS && r < obs_w.size(); r++)
      chk("w_seq", obs_w[r], tile_w[r]);
    chk("settle_gap", 64'(bv_first - lw_last), 64'(N_COLS + 3));
    chk("bv_len", 64'(obs_a.size()), 64'(exp_full.size()));
    chk("bv_contig", 64'(bv_last - bv_first + 1), 64'(obs_a.size()));
    for (int k = 0; k < obs_a.size() && k < exp_full.size(); k++) begin
      e = '0;
      for (int i = 0; i < N_ROWS; i++) begin
        src = SKEW ? (k - i) : k;
        if (src >= 0 && src < exp_full.size()) e[i*DW +: DW] = exp_full[src][i*DW +: DW];
      end
      chk("a_seq", obs_a[k], e);
    end
  endtask

  task automatic run_abort();
    bit ok;
    fill_rand();
    begin_tile(1'b0, ok);
    if (!ok) return;
    for (int b = 0; b < 2; b++) begin
      act_valid = 1'b1;
      act_data  = tile_a[b];
      @(negedge clk);
    end
    act_valid = 1'b0;
    abort     = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_block_valid", 64'(block_valid), 64'(0));
    chk("abort_load_weight", 64'(load_weight), 64'(0));
    chk("abort_a_in_flat", a_in_flat, 64'(0));
    chk("abort_act_ready", 64'(act_ready), 64'(0));
    chk("abort_k_count", 64'(k_count), 64'(2));
    repeat (30) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(0));
    chk("abort_still_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    int  n;
    bit  last;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_w_ready", 64'(w_ready), 64'(0));
    chk("rst_act_ready", 64'(act_ready), 64'(0));
    chk("rst_load_weight", 64'(load_weight), 64'(0));
    chk("rst_block_valid", 64'(block_valid), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_k_count", 64'(k_count), 64'(0));
    chk("rst_k_overflow", 64'(k_overflow), 64'(0));
    chk("rst_a_in_flat", a_in_flat, 64'(0));
    chk("rst_b_in_flat", b_in_flat, 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    fill_const(8'd2, 8'd1);
    run_tile(8, 1'b1, 1'b0, 1'b0);
    fill_const(8'hFD, 8'd2);
    run_tile(8, 1'b1, 1'b0, 1'b0);
    fill_const(8'd2, 8'd1);
    run_tile(8, 1'b1, 1'b1, 1'b0);

    run_abort();
    fill_const(8'd2, 8'd1);
    run_tile(8, 1'b1, 1'b0, 1'b1);

    fill_rand();
    run_tile(MAX_K, 1'b0, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("overflow_sticky", 64'(k_overflow), 64'(1));
    fill_rand();
    run_tile(5, 1'b1, 1'b0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      fill_rand();
      last = ($urandom_range(0, 3) != 0);
      n    = last ? $urandom_range(1, MAX_K) : MAX_K;
      run_tile(n, last, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d compares failed", n_err, n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
